// File: rtl/t_counter_pkg.sv
// Shared types, defaults and helpers for the T flip-flop up/down counter.
// Imported by the counter top; the cell itself needs nothing from here.
package t_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_MAX_COUNT = (1 << DEF_WIDTH) - 1;

  // Load values above the terminal count saturate to it.
  function automatic logic [15:0] clamp_load(input logic [15:0] val, input logic [15:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop: toggles on a rising clock edge when t=1.
// Asynchronous active-high reset clears the cell to 0.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  assign q_d = q_q ^ t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/t_sync_updown_counter.sv
// Modulo-(MAX_COUNT+1) up/down counter: per-bit toggle logic driving a bank of T-FF cells.
// Optional T_COUNTER_SATURATE_EN: hold at the terminal count instead of wrapping (wrap tied low).
module t_sync_updown_counter
  import t_counter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  dir_e             dir;
  logic [WIDTH-1:0] load_c;
  logic [WIDTH-1:0] cnt_t;
  logic             at_term;
  logic             run;

  assign dir     = dir_e'(up_dn);
  assign load_c  = WIDTH'(clamp_load(16'(load_val), 16'(MAX_COUNT)));
  assign at_term = (dir == DIR_UP) ? (q == MAX_V) : (q == '0);

  // Bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
  always_comb begin
    cnt_t = '0;
    run   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_t[i] = run;
      run      = run & ((dir == DIR_UP) ? q[i] : ~q[i]);
    end
  end

  always_comb begin
    t_vec = '0;
    if (rst) begin
      t_vec = '0;
    end else if (load) begin
      t_vec = q ^ load_c;
    end else if (en) begin
      if (at_term) begin
`ifdef T_COUNTER_SATURATE_EN
        t_vec = '0;
`else
        // Up: q^q clears to 0. Down: q is 0, so toggling MAX_V lands on MAX_V.
        t_vec = (dir == DIR_UP) ? q : MAX_V;
`endif
      end else begin
        t_vec = cnt_t;
      end
    end
  end

  assign tc = ~rst & en & at_term;

`ifdef T_COUNTER_SATURATE_EN
  assign wrap = 1'b0;
`else
  logic wrap_q;
  logic wrap_d;

  assign wrap_d = tc & ~load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    t_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[g]),
      .q   (q[g])
    );
  end

endmodule
